// File: rtl/fetch_pc_ctrl_pkg.sv
// Shared types for the fetch PC sequencer: PC width, 2-bit predictor counter
// encodings and the BTB entry layout.
package fetch_pc_ctrl_pkg;

    localparam int PC_W = 13;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    // The tag is kept at full PC width so the struct does not depend on the
    // index width; only pc >> INDEX_W is ever stored in it.
    typedef struct packed {
        logic            valid;
        logic [PC_W-1:0] tag;
        logic [PC_W-1:0] target;
        ctr_e            ctr;
    } btb_entry_t;

endpackage

// File: rtl/btb_table.sv
// Direct-mapped branch target buffer: one combinational lookup port and one
// training port with 2-bit saturating-counter update, synchronous reset.
module btb_table
    import fetch_pc_ctrl_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int INDEX_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [PC_W-1:0] rd_pc,
    output logic            rd_taken,
    output logic [PC_W-1:0] rd_target,
    input  logic            wr_en,
    input  logic [PC_W-1:0] wr_pc,
    input  logic            wr_taken,
    input  logic [PC_W-1:0] wr_target
);

    btb_entry_t table_r [ENTRIES];

    btb_entry_t       rd_entry_s;
    btb_entry_t       wr_old_s;
    btb_entry_t       wr_new_s;
    logic             wr_we_s;
    logic [INDEX_W-1:0] rd_idx_s;
    logic [INDEX_W-1:0] wr_idx_s;

    function automatic logic [PC_W-1:0] tag_of(input logic [PC_W-1:0] pc);
        return pc >> INDEX_W;
    endfunction

    function automatic ctr_e ctr_next(input ctr_e ctr, input logic taken);
        ctr_e r;
        case (ctr)
            SNT:     r = taken ? WNT : SNT;
            WNT:     r = taken ? WT  : SNT;
            WT:      r = taken ? ST  : WNT;
            ST:      r = taken ? ST  : WT;
            default: r = WNT;
        endcase
        return r;
    endfunction

    assign rd_idx_s = rd_pc[INDEX_W-1:0];
    assign wr_idx_s = wr_pc[INDEX_W-1:0];

    // Lookup: predict taken only on a valid tag hit with the counter in a taken state
    always_comb begin
        rd_entry_s = table_r[rd_idx_s];
        rd_target  = rd_entry_s.target;
        if (rd_entry_s.valid && (rd_entry_s.tag == tag_of(rd_pc)) && rd_entry_s.ctr[1]) begin
            rd_taken = 1'b1;
        end else begin
            rd_taken = 1'b0;
        end
    end

    // Training: update counter/target on a hit, allocate on a taken miss
    always_comb begin
        wr_old_s = table_r[wr_idx_s];
        wr_new_s = wr_old_s;
        wr_we_s  = 1'b0;
        if (wr_en) begin
            if (wr_old_s.valid && (wr_old_s.tag == tag_of(wr_pc))) begin
                wr_we_s      = 1'b1;
                wr_new_s.ctr = ctr_next(wr_old_s.ctr, wr_taken);
                if (wr_taken) begin
                    wr_new_s.target = wr_target;
                end else begin
                    wr_new_s.target = wr_old_s.target;
                end
            end else if (wr_taken) begin
                wr_we_s  = 1'b1;
                wr_new_s = '{valid: 1'b1, tag: tag_of(wr_pc), target: wr_target, ctr: WT};
            end else begin
                wr_we_s = 1'b0;
            end
        end else begin
            wr_we_s = 1'b0;
        end
    end

    // Table storage; reset leaves every entry invalid with a weakly-not-taken counter
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_r[i] <= '{valid: 1'b0, tag: {PC_W{1'b0}}, target: {PC_W{1'b0}}, ctr: WNT};
            end
        end else if (wr_we_s) begin
            table_r[wr_idx_s] <= wr_new_s;
        end
    end

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Fetch PC register, next-PC selection and flush generation.
// Define FETCH_BPRED_EN to instantiate the BTB predictor; otherwise fetch is sequential.
module fetch_pc_ctrl
    import fetch_pc_ctrl_pkg::*;
#(
    parameter int              BTB_ENTRIES = 16,
    parameter int              INDEX_W     = 4,
    parameter logic [PC_W-1:0] RESET_PC    = 13'h0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            fail_predict,
    input  logic [PC_W-1:0] d_nextpc,
    input  logic [PC_W-1:0] d_pc,
    input  logic            d_resolve,
    input  logic            d_taken,
    output logic [PC_W-1:0] f_pc,
    output logic [PC_W-1:0] f_pc_predicted,
    output logic            flush
);

    logic [PC_W-1:0] f_pc_r;
    logic            pred_taken_s;
    logic [PC_W-1:0] pred_target_s;

`ifdef FETCH_BPRED_EN
    btb_table #(
        .ENTRIES (BTB_ENTRIES),
        .INDEX_W (INDEX_W)
    ) u_btb (
        .clk       (clk),
        .rst       (rst),
        .rd_pc     (f_pc_r),
        .rd_taken  (pred_taken_s),
        .rd_target (pred_target_s),
        .wr_en     (d_resolve),
        .wr_pc     (d_pc),
        .wr_taken  (d_taken),
        .wr_target (d_nextpc)
    );
`else
    logic unused_inputs_s;

    assign pred_taken_s    = 1'b0;
    assign pred_target_s   = {PC_W{1'b0}};
    assign unused_inputs_s = ^{d_resolve, d_pc, d_taken, 32'(BTB_ENTRIES), 32'(INDEX_W)};
`endif

    // Predicted successor of the current fetch PC
    always_comb begin
        if (pred_taken_s) begin
            f_pc_predicted = pred_target_s;
        end else begin
            f_pc_predicted = f_pc_r + 13'd1;
        end
    end

    // Fetch PC: reset, then redirect (which beats stall), then hold, then prediction
    always_ff @(posedge clk) begin
        if (rst) begin
            f_pc_r <= RESET_PC;
        end else if (fail_predict) begin
            f_pc_r <= d_nextpc;
        end else if (stall) begin
            f_pc_r <= f_pc_r;
        end else begin
            f_pc_r <= f_pc_predicted;
        end
    end

    assign f_pc  = f_pc_r;
    assign flush = fail_predict & ~rst;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Directed self-checking bench for fetch_pc_ctrl; prediction expectations
// follow whether FETCH_BPRED_EN is defined.
module tb_fetch_pc_ctrl;

`ifdef FETCH_BPRED_EN
    localparam bit BP = 1'b1;
`else
    localparam bit BP = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        stall;
    logic        fail_predict;
    logic [12:0] d_nextpc;
    logic [12:0] d_pc;
    logic        d_resolve;
    logic        d_taken;
    logic [12:0] f_pc;
    logic [12:0] f_pc_predicted;
    logic        flush;

    int checks = 0;
    int errors = 0;

    fetch_pc_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .fail_predict   (fail_predict),
        .d_nextpc       (d_nextpc),
        .d_pc           (d_pc),
        .d_resolve      (d_resolve),
        .d_taken        (d_taken),
        .f_pc           (f_pc),
        .f_pc_predicted (f_pc_predicted),
        .flush          (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stall        = 1'b0;
        fail_predict = 1'b0;
        d_resolve    = 1'b0;
        d_taken      = 1'b0;
        d_pc         = 13'h0000;
        d_nextpc     = 13'h0000;
    endtask

    task automatic redirect(input logic [12:0] pc);
        fail_predict = 1'b1;
        d_nextpc     = pc;
        step();
        clear_inputs();
    endtask

    task automatic resolve(input logic [12:0] pc, input logic taken, input logic [12:0] nextpc);
        d_resolve = 1'b1;
        d_pc      = pc;
        d_taken   = taken;
        d_nextpc  = nextpc;
        step();
        clear_inputs();
    endtask

    task automatic check_pred(input string name, input logic [12:0] pc, input logic [12:0] exp);
        redirect(pc);
        checks++;
        if (f_pc_predicted !== exp) begin
            errors++;
            $display("FAIL %s: f_pc=%h f_pc_predicted=%h expected %h", name, f_pc, f_pc_predicted, exp);
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        fail_predict = 1'b1;
        d_nextpc = 13'h0123;
        d_resolve = 1'b1;
        d_taken = 1'b1;
        d_pc = 13'h0000;
        #1;
        checks++;
        if (flush !== 1'b0) begin
            errors++;
            $display("FAIL reset_flush: got %b expected 0", flush);
        end
        step();
        step();
        clear_inputs();
        rst = 1'b0;
        checks++;
        if (f_pc !== 13'h0000) begin
            errors++;
            $display("FAIL reset_pc: got %h expected 0000", f_pc);
        end
        checks++;
        if (f_pc_predicted !== 13'h0001) begin
            errors++;
            $display("FAIL reset_pred: got %h expected 0001", f_pc_predicted);
        end
        checks++;
        if (flush !== 1'b0) begin
            errors++;
            $display("FAIL reset_flush_after: got %b expected 0", flush);
        end
        for (int i = 1; i <= 3; i++) begin
            step();
            checks++;
            if (f_pc !== 13'(i)) begin
                errors++;
                $display("FAIL seq_step: got %h expected %h", f_pc, 13'(i));
            end
        end
    endtask

    task automatic test_alloc();
        d_pc = 13'h0010;
        d_taken = 1'b1;
        d_nextpc = 13'h0040;
        d_resolve = 1'b1;
        fail_predict = 1'b1;
        #1;
        checks++;
        if (flush !== 1'b1) begin
            errors++;
            $display("FAIL alloc_flush: got %b expected 1", flush);
        end
        step();
        clear_inputs();
        checks++;
        if (f_pc !== 13'h0040) begin
            errors++;
            $display("FAIL alloc_redirect: got %h expected 0040", f_pc);
        end
        check_pred("alloc_pred", 13'h0010, BP ? 13'h0040 : 13'h0011);
    endtask

    task automatic test_hysteresis();
        resolve(13'h0010, 1'b0, 13'h0011);
        check_pred("hyst_wnt", 13'h0010, 13'h0011);
        resolve(13'h0010, 1'b1, 13'h0040);
        resolve(13'h0010, 1'b1, 13'h0040);
        resolve(13'h0010, 1'b0, 13'h0011);
        check_pred("hyst_st_to_wt", 13'h0010, BP ? 13'h0040 : 13'h0011);
        resolve(13'h0010, 1'b0, 13'h0011);
        check_pred("hyst_wnt2", 13'h0010, 13'h0011);
        resolve(13'h0010, 1'b0, 13'h0011);
        resolve(13'h0010, 1'b0, 13'h0011);
        check_pred("hyst_snt_sat", 13'h0010, 13'h0011);
        resolve(13'h0010, 1'b1, 13'h0040);
        check_pred("hyst_snt_up", 13'h0010, 13'h0011);
        resolve(13'h0010, 1'b1, 13'h0040);
        check_pred("hyst_back_wt", 13'h0010, BP ? 13'h0040 : 13'h0011);
    endtask

    task automatic test_stall();
        redirect(13'h0005);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (f_pc !== 13'h0005) begin
                errors++;
                $display("FAIL stall_hold: got %h expected 0005", f_pc);
            end
        end
        fail_predict = 1'b1;
        d_nextpc = 13'h0100;
        #1;
        checks++;
        if (flush !== 1'b1) begin
            errors++;
            $display("FAIL stall_flush: got %b expected 1", flush);
        end
        step();
        clear_inputs();
        checks++;
        if (f_pc !== 13'h0100) begin
            errors++;
            $display("FAIL stall_redirect: got %h expected 0100", f_pc);
        end
        step();
        checks++;
        if (f_pc !== 13'h0101) begin
            errors++;
            $display("FAIL after_stall_seq: got %h expected 0101", f_pc);
        end
        stall = 1'b1;
        resolve(13'h0007, 1'b1, 13'h00AB);
        check_pred("train_in_stall", 13'h0007, BP ? 13'h00AB : 13'h0008);
    endtask

    task automatic test_alias();
        check_pred("alias_miss", 13'h0020, 13'h0021);
        resolve(13'h0020, 1'b1, 13'h0080);
        check_pred("alias_new", 13'h0020, BP ? 13'h0080 : 13'h0021);
        check_pred("alias_old_evicted", 13'h0010, 13'h0011);
        resolve(13'h0030, 1'b0, 13'h0031);
        check_pred("miss_nt_nochange", 13'h0020, BP ? 13'h0080 : 13'h0021);
        redirect(13'h0010);
        d_resolve = 1'b1;
        d_pc = 13'h0010;
        d_taken = 1'b1;
        d_nextpc = 13'h0050;
        #1;
        checks++;
        if (f_pc_predicted !== 13'h0011) begin
            errors++;
            $display("FAIL same_cycle_prewrite: got %h expected 0011", f_pc_predicted);
        end
        step();
        clear_inputs();
        checks++;
        if (f_pc !== 13'h0011) begin
            errors++;
            $display("FAIL same_cycle_next: got %h expected 0011", f_pc);
        end
        check_pred("write_visible", 13'h0010, BP ? 13'h0050 : 13'h0011);
    endtask

    task automatic test_wrap();
        check_pred("wrap_pred", 13'h1FFF, 13'h0000);
        step();
        checks++;
        if (f_pc !== 13'h0000) begin
            errors++;
            $display("FAIL wrap_pc: got %h expected 0000", f_pc);
        end
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        test_reset();
        test_alloc();
        test_hysteresis();
        test_stall();
        test_alias();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_pc_ctrl.md
# fetch_pc_ctrl

Fetch-stage PC sequencer and branch predictor for the RV32I pipeline. It holds the fetch PC and predicts the next fetch PC from a direct-mapped branch target buffer (BTB) of 2-bit saturating counters. The prediction travels down the pipeline as `pc_predicted`. When decode-stage PC calculation reports a misprediction, the block redirects fetch, flushes the pipeline and trains the BTB from the resolved outcome. All PCs are 13-bit word addresses.

## Interface
Parameters:
- `BTB_ENTRIES`, 16: number of BTB entries; must be a power of two.
- `INDEX_W`, 4: log2(`BTB_ENTRIES`).
- `RESET_PC`, 13'h0000: fetch PC after reset.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `stall`, in, 1: hold the fetch PC.
- `fail_predict`, in, 1: decode-stage misprediction; already gated off while decode cannot compute the PC.
- `d_nextpc`, in, 13: resolved next PC of the decode instruction.
- `d_pc`, in, 13: PC of the decode instruction.
- `d_resolve`, in, 1: decode holds a resolved branch or jump. Pulses exactly once per instruction.
- `d_taken`, in, 1: resolved outcome is taken (branch condition true, or jal/jalr).
- `f_pc`, out, 13: current fetch PC (registered).
- `f_pc_predicted`, out, 13: predicted successor of `f_pc` (combinational).
- `flush`, out, 1: kill the fetch and decode instructions this cycle.

## Operation
- BTB entry fields: `valid`, `tag` = pc[12:INDEX_W], `target`[12:0], `ctr`[1:0]. The index is pc[INDEX_W-1:0].
- Lookup on `f_pc`: a hit requires `valid` set and a tag match. Predict taken on a hit with `ctr` >= 2.
  - Predicted taken: `f_pc_predicted` = `target`.
  - Otherwise: `f_pc_predicted` = `f_pc`+1, modulo 2^13. 13'h1FFF wraps to 13'h0000.
- Next `f_pc`, in priority order:
  1. `rst`: `RESET_PC`.
  2. `fail_predict`: `d_nextpc`. Redirect overrides `stall`.
  3. `stall`: hold.
  4. Otherwise: `f_pc_predicted`.
- `flush` = `fail_predict` & ~`rst`. It is combinational.
- Training runs when `d_resolve`=1, indexed by `d_pc`. It is independent of `stall`.
  - Hit: `ctr` saturating +1 if taken, −1 if not taken. If taken, `target` ← `d_nextpc`.
  - Miss and taken: allocate the entry, overwriting any prior contents. Set `valid`=1, tag from `d_pc`, `target` ← `d_nextpc`, `ctr` ← 2'b10.
  - Miss and not taken: no change.

## Timing
- Reset values:
  - `f_pc` = `RESET_PC`.
  - `flush` = 0.
  - All BTB `valid` = 0 and `ctr` = 2'b01, so `f_pc_predicted` = `RESET_PC`+1.
  - Reset asserted mid-operation discards any pending redirect and training that cycle.
- The prediction is available in the same cycle as `f_pc`.
- Redirect latency is one cycle: `fail_predict` at cycle N gives `f_pc` = `d_nextpc` at N+1.
- A BTB write becomes visible to lookup in the following cycle. A lookup and a write to the same index in the same cycle use the pre-write contents.
- A `d_resolve` pulse coinciding with `fail_predict` does both training and redirect in that cycle.

## Configuration
- `FETCH_BPRED_EN` defined: BTB instantiated and predictions made as described above.
- `FETCH_BPRED_EN` undefined:
  - No BTB storage is instantiated.
  - `f_pc_predicted` = `f_pc`+1 always.
  - `d_resolve`, `d_pc` and `d_taken` are ignored.
  - Redirect, `stall` and `flush` behave identically to the enabled build.

## Structure
- Shared package holds:
  - `PC_W`=13.
  - Counter encodings SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11.
  - The BTB entry struct typedef.
- One sub-module, `btb_table`:
  - Register array with one combinational read port and one write port.
  - Contains the saturating-counter update logic.
  - Synchronous reset.
- The top level holds the `f_pc` register, the next-PC mux and `flush`.

## Test plan
- Reset: `rst`=1 for 2 cycles, then 0 → `f_pc`=0x000, `f_pc_predicted`=0x001, `flush`=0. With no further events `f_pc` steps 0x001, 0x002, 0x003.
- Taken-branch allocation:
  - Stimulus: `d_pc`=0x010, `d_taken`=1, `d_nextpc`=0x040, `d_resolve`=1, `fail_predict`=1.
  - Response: `flush`=1 that cycle and `f_pc`=0x040 next cycle.
  - Later, with `f_pc`=0x010: `f_pc_predicted`=0x040.
- Counter hysteresis, after the allocation above (`ctr`=WT):
  - One not-taken resolve at 0x010 → `ctr`=WNT; `f_pc`=0x010 predicts 0x011.
  - Two taken resolves → `ctr`=ST.
  - Three not-taken resolves → SNT; further not-taken stays SNT.
- Stall vs redirect:
  - `stall`=1 for 3 cycles at `f_pc`=0x005 → `f_pc` holds 0x005.
  - `fail_predict`=1 with `d_nextpc`=0x100 during the stall → `f_pc`=0x100 next cycle.
- Aliasing:
  - Entry allocated for 0x010 → 0x040. Lookup of 0x020 (same index 0) predicts 0x021.
  - Taken resolve at 0x020 → 0x080 replaces the entry; 0x010 then predicts 0x011.
- Wrap: `f_pc`=0x1FFF with no hit → next `f_pc`=0x0000.
